// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Oversample ticks per bit. Must be even and at least 4 so that a mid-bit
  // point exists on a whole tick.
  localparam int UART_OVERSAMPLE = 16;

  // Data bits per frame (5..8). The link is LSB first, no parity, 1 stop bit.
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,   // line idle, waiting for a falling edge
    START,  // timing to the middle of the start bit
    DATA,   // sampling data bits at mid-bit
    STOP,   // sampling the stop bit
    BREAK   // bad stop seen; wait for the line to return high
  } uart_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte delivery bundle from the UART receiver to the command decoder.
// Latency: n/a (wires only).
// Backpressure: data/data_valid hold until data_ready; frame_err/overrun are single-cycle pulses.
//   master (receiver): drives data, data_valid, frame_err, overrun; samples data_ready
//   slave  (consumer): samples the byte and error pulses; drives data_ready
interface uart_receiver_if #(
  parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data,
    output data_valid,
    output frame_err,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  frame_err,
    input  overrun,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous UART line inputs, reset to a chosen level.
// Latency: 2 clocks from d to q.
// Backpressure: none; samples every clock.
//   clock, reset : system clock, asynchronous active-high reset
//   d            : asynchronous input
//   q            : synchronised output (RESET_VAL while in reset)
module uart_rx_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Reset value matches the idle level of the line so that leaving reset
  // never looks like a falling edge on its own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronises rx, frames 8N1-style bytes on the prescaler oversample tick, flags errors.
// Latency: byte visible on data/data_valid the clock after the mid-stop-bit tick; rx to FSM is 2 clocks.
// Backpressure: one-byte holding register; a byte completing while it is full and not being taken is dropped with an overrun pulse.
//   clock, reset : system clock, asynchronous active-high reset
//   scaled       : one-cycle oversample tick, OVERSAMPLE per bit time
//   rx           : asynchronous serial input, idles high
//   bus (master) : data, data_valid, data_ready, frame_err, overrun
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic clock,
  input  logic reset,
  input  logic scaled,
  input  logic rx,
  uart_receiver_if.master bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Line synchroniser
  // --------------------------------------------------------------------------
  logic rx_s;

  uart_rx_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic tick_mid;
  logic tick_end;

  // Strobes decoded from the current state; only ever set on a tick.
  logic tick_clr;
  logic tick_inc;
  logic bit_clr;
  logic sample_bit;
  logic byte_done;
  logic stop_bad;

  assign tick_mid = (tick_cnt == TICK_MID);
  assign tick_end = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (scaled) begin
      case (state)
        IDLE:  if (!rx_s) state_nxt = START;
        // Mid start bit: a line back high by now was a glitch, not a frame.
        START: if (tick_mid) state_nxt = rx_s ? IDLE : DATA;
        DATA:  if (tick_end && (bit_cnt == BIT_LAST)) state_nxt = STOP;
        // Leaving at mid stop bit leaves half a bit to spot a back-to-back start.
        STOP:  if (tick_end) state_nxt = rx_s ? IDLE : BREAK;
        // A held-low line must rise before another frame is considered,
        // so a break reports a single framing error.
        BREAK: if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_clr   = 1'b0;
    tick_inc   = 1'b0;
    bit_clr    = 1'b0;
    sample_bit = 1'b0;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    if (scaled) begin
      case (state)
        IDLE: begin
          tick_clr = 1'b1;
        end
        START: begin
          if (tick_mid) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick_clr   = 1'b1;
            sample_bit = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
        STOP: begin
          if (tick_end) begin
            tick_clr  = 1'b1;
            byte_done = rx_s;
            stop_bad  = !rx_s;
          end else begin
            tick_inc = 1'b1;
          end
        end
        default: begin
          tick_clr = 1'b1;
        end
      endcase
    end
  end

  // Counters and shift register. Data arrives LSB first, so shifting right
  // with the new bit entering at the MSB leaves the byte aligned after the
  // last sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (tick_clr) begin
        tick_cnt <= '0;
      end else if (tick_inc) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (sample_bit) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (sample_bit) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register and error pulses (runs every clock)
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      // Only a full register that is not draining this cycle forces a drop.
      overrun_q   <= byte_done && valid_q && !bus.data_ready;

      if (byte_done && (!valid_q || bus.data_ready)) begin
        // Covers both an empty register and a simultaneous hand-off, where
        // the old byte leaves as the new one lands and valid stays high.
        data_q  <= shift_reg;
        valid_q <= 1'b1;
      end else if (valid_q && bus.data_ready) begin
        // data is left as-is; only the valid flag drops.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule
